// File: rtl/jc_bidir_n.sv
// Parametrised bidirectional Johnson (twisted-ring) counter with phase index,
// indexed load, wrap pulse and self-correcting illegal-state detection.
module jc_bidir_n #(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             go_left,
  input  logic             go_right,
  input  logic             load,
  input  logic [PW-1:0]    load_phase,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  localparam int          NSTATES = 2 * WIDTH;
  localparam logic [PW-1:0] LAST  = PW'(NSTATES - 1);
  localparam logic [PW-1:0] ONE   = PW'(1);

  // Phase k <= WIDTH: lowest k bits set; phase WIDTH+j: ones above the lowest j bits.
  function automatic logic [WIDTH-1:0] code_of(input logic [PW-1:0] k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(k) <= WIDTH) c[i] = (i < int'(k));
      else                  c[i] = (i >= int'(k) - WIDTH);
    end
    return c;
  endfunction

  // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
  function automatic logic is_valid(input logic [WIDTH-1:0] v);
    int unsigned edges;
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) edges++;
    end
    return (edges <= 1);
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;
  logic             load_ok;
  logic             q_valid;

  assign load_ok = (int'(load_phase) < NSTATES);
  assign q_valid = is_valid(q_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    q_d       = q_q;
    phase_d   = phase_q;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    if (load) begin
      // An out-of-range phase index is dropped and also suppresses stepping.
      if (load_ok) begin
        q_d     = code_of(load_phase);
        phase_d = load_phase;
      end
    end else if (!q_valid) begin
      q_d       = '0;
      phase_d   = '0;
      illegal_d = 1'b1;
    end else if (en && go_left) begin
      q_d     = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      phase_d = (phase_q == LAST) ? '0 : phase_q + ONE;
      wrap_d  = (phase_q == LAST);
    end else if (en && go_right) begin
      q_d     = {~q_q[0], q_q[WIDTH-1:1]};
      phase_d = (phase_q == '0) ? LAST : phase_q - ONE;
      wrap_d  = (phase_q == ONE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      phase_q   <= '0;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
      illegal_q <= illegal_d;
    end
  end

  assign q       = q_q;
  assign phase   = phase_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_jc_bidir_n.sv
// Scoreboard bench for jc_bidir_n at WIDTH = 4, 2 and 7: stimulus pushes the
// hand-computed expected outputs, a monitor pops and compares after each edge.
module tb_jc_bidir_n;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  ph;
    logic        w;
    logic        il;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b1, en4 = 1'b0, gl4 = 1'b0, gr4 = 1'b0, ld4 = 1'b0;
  logic [2:0] lp4 = '0;
  logic [3:0] q4;
  logic [2:0] ph4;
  logic       wr4, il4;

  logic       rst2 = 1'b1, en2 = 1'b0, gl2 = 1'b0, gr2 = 1'b0, ld2 = 1'b0;
  logic [1:0] lp2 = '0;
  logic [1:0] q2;
  logic [1:0] ph2;
  logic       wr2, il2;

  logic       rst7 = 1'b1, en7 = 1'b0, gl7 = 1'b0, gr7 = 1'b0, ld7 = 1'b0;
  logic [3:0] lp7 = '0;
  logic [6:0] q7;
  logic [3:0] ph7;
  logic       wr7, il7;

  jc_bidir_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .go_left(gl4), .go_right(gr4),
    .load(ld4), .load_phase(lp4), .q(q4), .phase(ph4), .wrap(wr4), .illegal(il4)
  );
  jc_bidir_n #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .go_left(gl2), .go_right(gr2),
    .load(ld2), .load_phase(lp2), .q(q2), .phase(ph2), .wrap(wr2), .illegal(il2)
  );
  jc_bidir_n #(.WIDTH(7)) dut7 (
    .clk(clk), .rst(rst7), .en(en7), .go_left(gl7), .go_right(gr7),
    .load(ld7), .load_phase(lp7), .q(q7), .phase(ph7), .wrap(wr7), .illegal(il7)
  );

  exp_t sb4[$];
  exp_t sb2[$];
  exp_t sb7[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic cmp(input exp_t e, input int aq, input int aph, input logic aw, input logic ai);
    check({e.tag, " q"},       aq,       int'(e.q));
    check({e.tag, " phase"},   aph,      int'(e.ph));
    check({e.tag, " wrap"},    int'(aw), int'(e.w));
    check({e.tag, " illegal"}, int'(ai), int'(e.il));
  endtask

  // Monitor: outputs of the edge that consumed the oldest queued stimulus.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb4.size() != 0) begin
      e = sb4.pop_front();
      cmp(e, int'(q4), int'(ph4), wr4, il4);
    end
    if (sb2.size() != 0) begin
      e = sb2.pop_front();
      cmp(e, int'(q2), int'(ph2), wr2, il2);
    end
    if (sb7.size() != 0) begin
      e = sb7.pop_front();
      cmp(e, int'(q7), int'(ph7), wr7, il7);
    end
  end

  // Applies one cycle of inputs on the falling edge and queues the expected result.
  task automatic drive(input int w, input logic r, input logic en, input logic gl,
                       input logic gr, input logic ld, input int lp,
                       input int eq, input int eph, input logic ew, input logic ei,
                       input string tag, input bit frc = 1'b0);
    exp_t e;
    @(negedge clk);
    if (frc) begin
      force dut4.q_q = 4'b0101;
      #1;
      release dut4.q_q;
    end
    e.q = 16'(eq); e.ph = 8'(eph); e.w = ew; e.il = ei; e.tag = tag;
    case (w)
      4: begin
        rst4 = r; en4 = en; gl4 = gl; gr4 = gr; ld4 = ld; lp4 = 3'(lp);
        sb4.push_back(e);
      end
      2: begin
        rst2 = r; en2 = en; gl2 = gl; gr2 = gr; ld2 = ld; lp2 = 2'(lp);
        sb2.push_back(e);
      end
      default: begin
        rst7 = r; en7 = en; gl7 = gl; gr7 = gr; ld7 = ld; lp7 = 4'(lp);
        sb7.push_back(e);
      end
    endcase
  endtask

  // Expected 7-bit Johnson code for phase k, built from whole-word masks.
  function automatic int code7(input int k);
    if (k <= 7) return (1 << k) - 1;
    return 32'h7F ^ ((1 << (k - 7)) - 1);
  endfunction

  initial begin
    int lq4 [9] = '{1, 3, 7, 15, 14, 12, 8, 0, 1};
    int lq2 [5] = '{1, 3, 2, 0, 1};

    // WIDTH=4: reset, then nine left steps through one full revolution.
    drive(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "w4 reset");
    for (int i = 0; i < 9; i++)
      drive(4, 0, 1, 1, 0, 0, 0, lq4[i], (i + 1) % 8, (i == 7), 0, $sformatf("w4 left%0d", i));

    // Right steps from reset, load phase 1, then right wrap 1 -> 0.
    drive(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "w4 reset2");
    drive(4, 0, 1, 0, 1, 0, 0, 8,  7, 0, 0, "w4 right0");
    drive(4, 0, 1, 0, 1, 0, 0, 12, 6, 0, 0, "w4 right1");
    drive(4, 0, 1, 0, 1, 0, 0, 14, 5, 0, 0, "w4 right2");
    drive(4, 0, 1, 0, 1, 1, 1, 1,  1, 0, 0, "w4 load1");
    drive(4, 0, 1, 0, 1, 0, 0, 0,  0, 1, 0, "w4 rwrap");

    // Both directions high: left wins; with en low the state holds.
    drive(4, 0, 0, 0, 0, 1, 2, 3, 2, 0, 0, "w4 load2");
    drive(4, 0, 1, 1, 1, 0, 0, 7, 3, 0, 0, "w4 both");
    for (int i = 0; i < 3; i++)
      drive(4, 0, 0, 1, 1, 0, 0, 7, 3, 0, 0, $sformatf("w4 hold%0d", i));

    // Load beats a requested step; load to phase 0 gives no wrap.
    drive(4, 0, 1, 1, 0, 1, 5, 14, 5, 0, 0, "w4 load5");
    drive(4, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, "w4 load0");

    // Reset beats load and step.
    drive(4, 0, 0, 0, 0, 1, 6, 12, 6, 0, 0, "w4 load6");
    drive(4, 1, 1, 1, 0, 1, 3, 0,  0, 0, 0, "w4 rstwin");

    // Corrupt q with en low: corrected to 0 with a single illegal pulse.
    drive(4, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, "w4 pre0");
    drive(4, 0, 1, 1, 0, 0, 0, 3, 2, 0, 0, "w4 pre1");
    drive(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "w4 illegal", 1'b1);
    drive(4, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, "w4 postfix");

    // WIDTH=2: four-state revolution, then right wrap and right underflow.
    drive(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "w2 reset");
    for (int i = 0; i < 5; i++)
      drive(2, 0, 1, 1, 0, 0, 0, lq2[i], (i + 1) % 4, (i == 3), 0, $sformatf("w2 left%0d", i));
    drive(2, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, "w2 rwrap");
    drive(2, 0, 1, 0, 1, 0, 0, 2, 3, 0, 0, "w2 under");

    // WIDTH=7: fourteen-state revolution, out-of-range loads, right wrap.
    drive(7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "w7 reset");
    for (int i = 0; i < 15; i++)
      drive(7, 0, 1, 1, 0, 0, 0, code7((i + 1) % 14), (i + 1) % 14, (i == 13), 0,
            $sformatf("w7 left%0d", i));
    drive(7, 0, 1, 1, 0, 1, 15, 1, 1, 0, 0, "w7 badload15");
    drive(7, 0, 1, 1, 0, 1, 14, 1, 1, 0, 0, "w7 badload14");
    drive(7, 0, 1, 0, 1, 0, 0,  0, 0, 1, 0, "w7 rwrap");
    drive(7, 0, 1, 0, 1, 0, 0, 64, 13, 0, 0, "w7 under");

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard drained", sb4.size() + sb2.size() + sb7.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
